// File: rtl/tstate_sequencer_pkg.sv
// Shared types, default sizing and the index-to-one-hot helper for the T-state sequencer.
// Optional integrity checker is enabled by TSEQ_ONEHOT_CHECK_EN.
package tseq_pkg;
   typedef enum logic {
      TSEQ_RUN    = 1'b0,
      TSEQ_HALTED = 1'b1
   } tseq_state_e;

   localparam int TSEQ_NUM_T_DEF   = 6;
   localparam int TSEQ_FETCH_T_DEF = 3;
   localparam int TSEQ_CNT_W_DEF   = 16;
   localparam int TSEQ_MAX_T       = 16;

   function automatic logic [TSEQ_MAX_T-1:0] idx_to_onehot(input logic [3:0] idx);
      logic [TSEQ_MAX_T-1:0] one;
      one = TSEQ_MAX_T'(1);
      return one << idx;
   endfunction
endpackage

// File: rtl/tstate_sequencer_if.sv
// Decoder-facing bundle: control requests in, T-state decode and status out.
interface tstate_sequencer_if
   import tseq_pkg::*;
#(
   parameter int NUM_T = TSEQ_NUM_T_DEF,
   parameter int CNT_W = TSEQ_CNT_W_DEF
);
   localparam int IW = $clog2(NUM_T);

   logic             run_en;
   logic             end_instr;
   logic             halt;
   logic             resume;
   logic [NUM_T-1:0] t_state;
   logic [IW-1:0]    t_index;
   logic             fetch;
   logic             instr_start;
   logic             halted;
   logic [CNT_W-1:0] instr_count;
   logic             err;

   modport master (
      output run_en, end_instr, halt, resume,
      input  t_state, t_index, fetch, instr_start, halted, instr_count, err
   );

   modport slave (
      input  run_en, end_instr, halt, resume,
      output t_state, t_index, fetch, instr_start, halted, instr_count, err
   );
endinterface

// File: rtl/tseq_onehot_check.sv
// Combinational integrity check of the registered T-state; raises a violation pulse.
// Compiled only when TSEQ_ONEHOT_CHECK_EN is defined.
`ifdef TSEQ_ONEHOT_CHECK_EN
module tseq_onehot_check
   import tseq_pkg::*;
#(
   parameter int NUM_T = TSEQ_NUM_T_DEF
) (
   input  tseq_state_e              state,
   input  logic [NUM_T-1:0]         t_state,
   input  logic [$clog2(NUM_T)-1:0] t_index,
   output logic                     violation
);
   logic onehot;
   logic consistent;

   assign onehot     = (t_state != '0) && ((t_state & (t_state - NUM_T'(1))) == '0);
   assign consistent = (TSEQ_MAX_T'(t_state) == idx_to_onehot(4'(t_index)));

   always_comb begin
      violation = 1'b0;
      if (state == TSEQ_RUN) begin
         violation = !onehot || !consistent;
      end else begin
         violation = (t_state != '0);
      end
   end
endmodule
`endif

// File: rtl/tstate_sequencer.sv
// SAP-1 T-state ring with early end, stall, halt/resume and retired-instruction count; updates on negedge.
// Optional sticky integrity check under TSEQ_ONEHOT_CHECK_EN (err tied low otherwise).
module tstate_sequencer
   import tseq_pkg::*;
#(
   parameter int NUM_T   = TSEQ_NUM_T_DEF,
   parameter int FETCH_T = TSEQ_FETCH_T_DEF,
   parameter int CNT_W   = TSEQ_CNT_W_DEF
) (
   input logic               clk,
   input logic               reset,
   tstate_sequencer_if.slave bus
);
   localparam int               IW        = $clog2(NUM_T);
   localparam logic [IW-1:0]    LAST_IDX  = IW'(NUM_T - 1);
   localparam logic [IW-1:0]    FETCH_IDX = IW'(FETCH_T);
   localparam logic [NUM_T-1:0] T1_VEC    = NUM_T'(1);

   tseq_state_e      state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [NUM_T-1:0] t_state_q, t_state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             exec;
   logic             viol;

   assign exec = (idx_q >= FETCH_IDX);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      t_state_d = t_state_q;
      cnt_d     = cnt_q;
      if (bus.run_en) begin
         case (state_q)
            TSEQ_RUN: begin
               // halt takes precedence over end_instr; a halted instruction never retires
               if (bus.halt && exec) begin
                  state_d   = TSEQ_HALTED;
                  idx_d     = '0;
                  t_state_d = '0;
               end else if ((idx_q == LAST_IDX) || (bus.end_instr && exec)) begin
                  idx_d     = '0;
                  t_state_d = T1_VEC;
                  cnt_d     = cnt_q + CNT_W'(1);
               end else begin
                  idx_d     = idx_q + IW'(1);
                  t_state_d = t_state_q << 1;
               end
            end
            TSEQ_HALTED: begin
               if (bus.resume) begin
                  state_d   = TSEQ_RUN;
                  idx_d     = '0;
                  t_state_d = T1_VEC;
               end
            end
            default: ;
         endcase
      end
      if (viol) begin
         state_d   = TSEQ_RUN;
         idx_d     = '0;
         t_state_d = T1_VEC;
         cnt_d     = cnt_q;
      end
   end

   always_ff @(negedge clk) begin
      if (reset) begin
         state_q   <= TSEQ_RUN;
         idx_q     <= '0;
         t_state_q <= T1_VEC;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         t_state_q <= t_state_d;
         cnt_q     <= cnt_d;
      end
   end

`ifdef TSEQ_ONEHOT_CHECK_EN
   logic err_q;

   tseq_onehot_check #(
      .NUM_T(NUM_T)
   ) u_check (
      .state    (state_q),
      .t_state  (t_state_q),
      .t_index  (idx_q),
      .violation(viol)
   );

   always_ff @(negedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (viol) begin
         err_q <= 1'b1;
      end
   end

   assign bus.err = err_q;
`else
   assign viol    = 1'b0;
   assign bus.err = 1'b0;
`endif

   assign bus.t_state     = t_state_q;
   assign bus.t_index     = idx_q;
   assign bus.fetch       = (state_q == TSEQ_RUN) && (idx_q < FETCH_IDX);
   assign bus.instr_start = (state_q == TSEQ_RUN) && (idx_q == '0);
   assign bus.halted      = (state_q == TSEQ_HALTED);
   assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_tstate_sequencer.sv
// Directed vector bench for tstate_sequencer: default 6/3/16 instance plus a small 4/2/2 instance.
module tb_tstate_sequencer;
   import tseq_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic s_reset;

   always #5 clk = ~clk;

   tstate_sequencer_if #(.NUM_T(6), .CNT_W(16)) m_if ();
   tstate_sequencer_if #(.NUM_T(4), .CNT_W(2))  s_if ();

   tstate_sequencer #(.NUM_T(6), .FETCH_T(3), .CNT_W(16)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (m_if.slave)
   );

   tstate_sequencer #(.NUM_T(4), .FETCH_T(2), .CNT_W(2)) dut_s (
      .clk  (clk),
      .reset(s_reset),
      .bus  (s_if.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        rst, run, eoi, hlt, res;
      logic [5:0]  ts;
      logic [2:0]  idx;
      logic        f, s, h;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, run, eoi, hlt, res,
                      input logic [5:0] ts, input logic [2:0] idx,
                      input logic f, s, h, input logic [15:0] cnt);
      vec_t v;
      v.rst = rst; v.run = run; v.eoi = eoi; v.hlt = hlt; v.res = res;
      v.ts = ts; v.idx = idx; v.f = f; v.s = s; v.h = h; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, run, eoi, hlt, res);
      reset          = rst;
      m_if.run_en    = run;
      m_if.end_instr = eoi;
      m_if.halt      = hlt;
      m_if.resume    = res;
   endtask

   task automatic cyc(input logic rst, run);
      drive(rst, run, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
   endtask

   function automatic logic [28:0] m_obs();
      return {m_if.t_state, m_if.t_index, m_if.fetch, m_if.instr_start,
              m_if.halted, m_if.instr_count, m_if.err};
   endfunction

   initial begin
      //   rst run eoi hlt res  t_state   idx f  s  h  cnt
      add(0, 1, 0, 0, 0, 6'b000010, 1, 1, 0, 0, 0);
      add(0, 1, 0, 0, 0, 6'b000100, 2, 1, 0, 0, 0);
      add(0, 1, 0, 0, 0, 6'b001000, 3, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 6'b010000, 4, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 6'b100000, 5, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 6'b000001, 0, 1, 1, 0, 1);
      add(0, 1, 1, 0, 0, 6'b000010, 1, 1, 0, 0, 1);
      add(0, 1, 1, 0, 0, 6'b000100, 2, 1, 0, 0, 1);
      add(0, 1, 0, 0, 0, 6'b001000, 3, 0, 0, 0, 1);
      add(0, 1, 1, 0, 0, 6'b000001, 0, 1, 1, 0, 2);
      add(0, 1, 0, 0, 0, 6'b000010, 1, 1, 0, 0, 2);
      add(0, 1, 0, 0, 0, 6'b000100, 2, 1, 0, 0, 2);
      add(0, 1, 0, 0, 0, 6'b001000, 3, 0, 0, 0, 2);
      add(0, 1, 0, 0, 0, 6'b010000, 4, 0, 0, 0, 2);
      add(0, 1, 0, 1, 0, 6'b000000, 0, 0, 0, 1, 2);
      add(0, 1, 1, 1, 0, 6'b000000, 0, 0, 0, 1, 2);
      add(0, 0, 0, 0, 1, 6'b000000, 0, 0, 0, 1, 2);
      add(0, 1, 0, 0, 1, 6'b000001, 0, 1, 1, 0, 2);
      add(0, 1, 0, 0, 0, 6'b000010, 1, 1, 0, 0, 2);
      add(0, 1, 0, 0, 0, 6'b000100, 2, 1, 0, 0, 2);
      add(0, 1, 0, 0, 0, 6'b001000, 3, 0, 0, 0, 2);
      add(0, 1, 1, 1, 0, 6'b000000, 0, 0, 0, 1, 2);
      add(0, 1, 0, 0, 1, 6'b000001, 0, 1, 1, 0, 2);
      add(0, 1, 0, 1, 0, 6'b000010, 1, 1, 0, 0, 2);
      add(0, 1, 0, 0, 0, 6'b000100, 2, 1, 0, 0, 2);
      add(0, 1, 0, 0, 0, 6'b001000, 3, 0, 0, 0, 2);
      add(0, 1, 0, 0, 0, 6'b010000, 4, 0, 0, 0, 2);
      add(0, 1, 0, 0, 0, 6'b100000, 5, 0, 0, 0, 2);
      add(0, 0, 0, 0, 0, 6'b100000, 5, 0, 0, 0, 2);
      add(0, 0, 1, 0, 0, 6'b100000, 5, 0, 0, 0, 2);
      add(0, 0, 0, 0, 0, 6'b100000, 5, 0, 0, 0, 2);
      add(0, 1, 0, 0, 0, 6'b000001, 0, 1, 1, 0, 3);
      add(0, 1, 0, 0, 0, 6'b000010, 1, 1, 0, 0, 3);
      add(0, 1, 0, 0, 0, 6'b000100, 2, 1, 0, 0, 3);
      add(1, 1, 0, 0, 0, 6'b000001, 0, 1, 1, 0, 0);
      add(0, 1, 0, 0, 0, 6'b000010, 1, 1, 0, 0, 0);
      add(0, 1, 0, 0, 0, 6'b000100, 2, 1, 0, 0, 0);
      add(0, 1, 0, 0, 0, 6'b001000, 3, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 6'b010000, 4, 0, 0, 0, 0);
      add(0, 1, 0, 1, 0, 6'b000000, 0, 0, 0, 1, 0);
      add(1, 0, 0, 0, 0, 6'b000001, 0, 1, 1, 0, 0);

      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      s_reset          = 1'b1;
      s_if.run_en      = 1'b0;
      s_if.end_instr   = 1'b0;
      s_if.halt        = 1'b0;
      s_if.resume      = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      check("reset_state", 64'(m_obs()), 64'({6'b000001, 3'd0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0}));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].run, vecs[i].eoi, vecs[i].hlt, vecs[i].res);
         @(posedge clk);
         check($sformatf("vec%0d", i), 64'(m_obs()),
               64'({vecs[i].ts, vecs[i].idx, vecs[i].f, vecs[i].s, vecs[i].h, vecs[i].cnt, 1'b0}));
      end

      repeat (6) cyc(1'b0, 1'b1);
      check("post_wrap", 64'({m_if.t_state, m_if.t_index, m_if.instr_count}),
            64'({6'b000001, 3'd0, 16'd1}));

`ifdef TSEQ_ONEHOT_CHECK_EN
      repeat (2) cyc(1'b0, 1'b1);
      check("pre_corrupt", 64'({m_if.t_state, m_if.t_index}), 64'({6'b000100, 3'd2}));
      force dut.t_state_q = 6'b000011;
      #1;
      release dut.t_state_q;
      @(posedge clk);
      check("corrupt_recover", 64'({m_if.t_state, m_if.t_index, m_if.instr_count, m_if.err}),
            64'({6'b000001, 3'd0, 16'd1, 1'b1}));
      repeat (2) cyc(1'b0, 1'b1);
      check("err_sticky", 64'({m_if.t_state, m_if.err}), 64'({6'b000100, 1'b1}));
      cyc(1'b1, 1'b1);
      check("err_reset", 64'({m_if.t_state, m_if.instr_count, m_if.err}),
            64'({6'b000001, 16'd0, 1'b0}));
`else
      repeat (3) cyc(1'b0, 1'b1);
      check("err_tied_low", 64'({m_if.t_state, m_if.err}), 64'({6'b001000, 1'b0}));
`endif

      // Small instance: 4 states, 2 fetch, 2-bit counter
      @(posedge clk);
      check("s_reset_state", 64'({s_if.t_state, s_if.t_index, s_if.fetch, s_if.instr_count}),
            64'({4'b0001, 2'd0, 1'b1, 2'd0}));
      s_reset     = 1'b0;
      s_if.run_en = 1'b1;
      repeat (2) @(posedge clk);
      check("s_t3_fetch", 64'({s_if.t_state, s_if.fetch}), 64'({4'b0100, 1'b0}));
      repeat (2) @(posedge clk);
      check("s_instr1", 64'({s_if.t_state, s_if.instr_count}), 64'({4'b0001, 2'd1}));
      repeat (8) @(posedge clk);
      check("s_instr3", 64'({s_if.t_state, s_if.instr_count}), 64'({4'b0001, 2'd3}));
      repeat (8) @(posedge clk);
      check("s_instr5_wrap", 64'({s_if.t_state, s_if.instr_count}), 64'({4'b0001, 2'd1}));
      repeat (2) @(posedge clk);
      check("s_at_t3", 64'({s_if.t_state, s_if.t_index}), 64'({4'b0100, 2'd2}));
      s_reset = 1'b1;
      @(posedge clk);
      check("s_reset_mid", 64'({s_if.t_state, s_if.t_index, s_if.instr_count}),
            64'({4'b0001, 2'd0, 2'd0}));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/tstate_sequencer.md
# tstate_sequencer

Parametrised T-state generator for the SAP-1 control path, producing a one-hot T-state vector plus a binary index for the instruction decoder. It extends the fixed six-state ring with:
- a configurable state count and fetch length,
- early instruction termination, stall (hold), and halt/resume,
- a retired-instruction counter.

State updates on the falling clock edge, so that every other block updates cleanly on the rising edge.

## Interface
- NUM_T, 6, number of T-states per instruction; legal range 3..16
- FETCH_T, 3, number of fetch states (T1..T_FETCH_T); legal range 1..NUM_T-1
- CNT_W, 16, width of retired-instruction counter
- clk  in  1  single clock; all state updates on negedge clk
- reset  in  1  synchronous, active-high, sampled on negedge clk
- run_en  in  1  advance enable; low holds the current state
- end_instr  in  1  early termination request from the decoder; honoured only in execute states (index >= FETCH_T)
- halt  in  1  decoded HLT; honoured only in execute states
- resume  in  1  leave the halted state
- t_state  out  NUM_T  one-hot T-state; bit 0 = T1; all-zero when halted
- t_index  out  $clog2(NUM_T)  binary index of the active state; 0 when halted
- fetch  out  1  high while index < FETCH_T and not halted
- instr_start  out  1  high during T1
- halted  out  1  high in the HALTED state
- instr_count  out  CNT_W  number of instructions retired
- err  out  1  sticky integrity error; tied 0 without the macro

## Operation
FSM states are RUN and HALTED.

Reset values:
- state RUN, t_state = 1 (T1), t_index = 0
- fetch = 1, instr_start = 1, halted = 0
- instr_count = 0, err = 0

RUN, evaluated at each negedge in priority order:
1. reset
2. run_en = 0: hold everything
3. halt = 1 in an execute state: go to HALTED
4. wrap to T1 and increment instr_count, when index = NUM_T-1, or when end_instr = 1 in an execute state
5. otherwise advance index by 1, and shift t_state left by 1

HALTED:
- t_state = 0, t_index = 0, halted = 1; the counter holds.
- resume = 1 with run_en = 1: go to RUN at T1. No count on resume.
- end_instr and halt are ignored in HALTED.

Additional rules:
- A halt instruction does not retire, so instr_count does not increment on entry to HALTED.
- end_instr and halt asserted during fetch states are ignored; no latching.
- halt and end_instr asserted together: halt wins.
- instr_count wraps modulo 2^CNT_W.
- fetch, instr_start and halted are decoded combinationally from registered state. They add no cycles and are stable from the falling edge.

## Timing
- One T-state per clock period; the transition occurs on negedge.
- A full instruction takes NUM_T periods. With early termination it takes (k+1) periods, where k is the index at which end_instr was sampled (minimum FETCH_T+1).
- Inputs are sampled at negedge, so the decoder must drive them from posedge logic settled by mid-cycle.
- reset asserted mid-instruction or while halted: T1 at the next negedge, and the counter clears.
- run_en low across a wrap point: the wrap and the count occur on the first negedge with run_en high.

## Configuration
Macro TSEQ_ONEHOT_CHECK_EN.

When defined, every negedge checks for:
- RUN with t_state not one-hot, or
- t_state inconsistent with t_index, or
- HALTED with t_state non-zero.

On violation, err is set sticky until reset and the sequencer is forced to RUN/T1 without a count.

When undefined, the checker is absent, err is constant 0, and behaviour is otherwise identical.

## Structure
- Package tseq_pkg holds:
  - the state enum typedef (TSEQ_RUN, TSEQ_HALTED)
  - the default parameter constants
  - a function converting an index to a one-hot vector
- Sub-module tseq_onehot_check (compiled only under TSEQ_ONEHOT_CHECK_EN) holds the one-hot and consistency checker. It outputs a violation pulse; the sticky flag lives in the parent.

## Test plan
- Reset high for 2 edges, then run_en = 1 with defaults: t_state sequence 000001, 000010 … 100000, 000001; instr_count = 1 after the first wrap; fetch high for the first 3 states.
- end_instr = 1 sampled at index 3 (T4): next t_state = 000001, instr_count increments, and the instruction length is 4 periods. end_instr pulsed at index 1: ignored.
- halt = 1 at T5: t_state = 0, halted = 1, count unchanged. Then resume = 1: T1 on the next negedge. halt and end_instr together at T4: HALTED.
- run_en low for 3 edges at T6: T6 holds, then wrap and count on the first enabled edge.
- NUM_T = 4, FETCH_T = 2, CNT_W = 2: 5 full instructions give instr_count = 1 (wrap); reset at T3 gives T1 and count 0 on the next edge.
- With the macro defined, force t_state = 000011 via the bench: err = 1 sticky, next state T1, count unchanged. Without the macro, err stays 0.
